// File: rtl/game_pkg.sv
// game_pkg: shared state/result types and tile constants for the round sequencer.
package game_pkg;
  typedef enum logic [3:0] {
    S_LOAD_REQ, S_LOAD_WAIT, S_READY, S_MOVE_REQ, S_MOVE_WAIT, S_WRITE_REQ,
    S_WRITE_WAIT, S_CHECK, S_RESPAWN, S_TICK_WAIT, S_END
  } game_state_t;
  typedef enum logic [1:0] {RES_NONE, RES_WIN, RES_LOSE} result_t;
  localparam int POS_W_DEF = 10;
  localparam logic [POS_W_DEF-1:0] PAC_START_TILE = 10'd300;
  localparam logic [POS_W_DEF-1:0] GHOST_START_TILE = 10'd400;
  function automatic logic is_wait(game_state_t s);
    return s inside {S_LOAD_WAIT, S_MOVE_WAIT, S_WRITE_WAIT, S_TICK_WAIT};
  endfunction
endpackage

// File: rtl/game_round_ctrl_if.sv
// game_round_ctrl_if: handshake/status bundle between the round sequencer (master) and its agents (slave).
interface game_round_ctrl_if #(parameter int N_GHOSTS = 4, parameter int POS_W = 10, parameter int PELLET_W = 8);
  logic                      tick, start, play_again, load_done, write_done, pellet_eaten;
  logic [N_GHOSTS:0]         agent_done;
  logic [POS_W-1:0]          pac_pos;
  logic [N_GHOSTS*POS_W-1:0] ghost_pos;
  logic                      load_start, move_start, write_start, ready, game_over, user_won, wdog_err;
  logic [2:0]                lives_left;
  logic [PELLET_W-1:0]       pellets_left;
  modport master (
    input  tick, start, play_again, load_done, write_done, pellet_eaten, agent_done, pac_pos, ghost_pos,
    output load_start, move_start, write_start, ready, game_over, user_won, wdog_err, lives_left, pellets_left
  );
  modport slave (
    output tick, start, play_again, load_done, write_done, pellet_eaten, agent_done, pac_pos, ghost_pos,
    input  load_start, move_start, write_start, ready, game_over, user_won, wdog_err, lives_left, pellets_left
  );
endinterface

// File: rtl/game_collide_chk.sv
// game_collide_chk: Pacman/ghost collision detect, including head-on swaps against positions latched at move_start.
module game_collide_chk #(parameter int N_GHOSTS = 4, parameter int POS_W = 10) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      move_start,
  input  logic [POS_W-1:0]          pac_pos,
  input  logic [N_GHOSTS*POS_W-1:0] ghost_pos,
  output logic                      hit
);
  logic [POS_W-1:0]          r_pac_prev;
  logic [N_GHOSTS*POS_W-1:0] r_ghost_prev;
  logic [N_GHOSTS-1:0]       w_hit;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_pac_prev   <= '0;
      r_ghost_prev <= '0;
    end else if (move_start) begin
      r_pac_prev   <= pac_pos;
      r_ghost_prev <= ghost_pos;
    end
  for (genvar i = 0; i < N_GHOSTS; i++) begin : g_cmp
    assign w_hit[i] = pac_pos == ghost_pos[i*POS_W +: POS_W] ||
                      (pac_pos == r_ghost_prev[i*POS_W +: POS_W] && ghost_pos[i*POS_W +: POS_W] == r_pac_prev);
  end
  assign hit = |w_hit;
endmodule

// File: rtl/game_round_ctrl.sv
// game_round_ctrl: round sequencer (load -> ready -> move/write/check per frame -> end) for N ghosts.
// Optional per-phase watchdog enabled by defining GAME_WATCHDOG_EN.
module game_round_ctrl import game_pkg::*; #(
  parameter int N_GHOSTS     = 4,
  parameter int POS_W        = POS_W_DEF,
  parameter int LIVES        = 3,
  parameter int PELLET_W     = 8,
  parameter int PELLETS_INIT = 240
`ifdef GAME_WATCHDOG_EN
  , parameter int WDOG_CYC   = 4096
`endif
) (
  input logic clk,
  input logic reset,
  game_round_ctrl_if.master bus
);
  game_state_t         r_state, w_nom, w_next;
  result_t             r_result;
  logic                r_load_start, r_move_start, r_write_start, r_tick_pend;
  logic [N_GHOSTS:0]   r_done;
  logic [2:0]          r_lives;
  logic [PELLET_W-1:0] r_pellets;
  logic                w_hit, w_to, w_restart, w_eat;

  game_collide_chk #(.N_GHOSTS(N_GHOSTS), .POS_W(POS_W)) u_collide (
    .clk(clk), .reset(reset), .move_start(r_move_start),
    .pac_pos(bus.pac_pos), .ghost_pos(bus.ghost_pos), .hit(w_hit)
  );

  // LOAD_REQ holds until its pulse has been issued, so the first cycle after reset stays quiet
  always_comb begin
    w_nom = r_state;
    case (r_state)
      S_LOAD_REQ:   w_nom = r_load_start ? S_LOAD_WAIT : S_LOAD_REQ;
      S_LOAD_WAIT:  w_nom = bus.load_done ? S_READY : S_LOAD_WAIT;
      S_READY:      w_nom = bus.start ? S_MOVE_REQ : S_READY;
      S_MOVE_REQ:   w_nom = S_MOVE_WAIT;
      S_MOVE_WAIT:  w_nom = &r_done ? S_WRITE_REQ : S_MOVE_WAIT;
      S_WRITE_REQ:  w_nom = S_WRITE_WAIT;
      S_WRITE_WAIT: w_nom = bus.write_done ? S_CHECK : S_WRITE_WAIT;
      S_CHECK:      w_nom = r_pellets == '0 ? S_END : !w_hit ? S_TICK_WAIT : r_lives <= 3'd1 ? S_END : S_RESPAWN;
      S_RESPAWN:    w_nom = S_LOAD_WAIT;
      S_TICK_WAIT:  w_nom = (bus.tick || r_tick_pend) ? S_MOVE_REQ : S_TICK_WAIT;
      S_END:        w_nom = bus.play_again ? S_LOAD_REQ : S_END;
      default:      w_nom = S_LOAD_REQ;
    endcase
  end

  assign w_next    = w_to ? S_END : w_nom;
  assign w_restart = r_state == S_END && w_next == S_LOAD_REQ;
  assign w_eat     = bus.pellet_eaten && (r_state == S_MOVE_WAIT || r_state == S_WRITE_WAIT) && r_pellets != '0;

`ifdef GAME_WATCHDOG_EN
  localparam int WCNT_W = $clog2(WDOG_CYC + 1);
  logic [WCNT_W-1:0] r_wcnt;
  logic              r_wdog;
  assign w_to = is_wait(r_state) && w_nom == r_state && r_wcnt == WCNT_W'(WDOG_CYC - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_wcnt <= '0;
      r_wdog <= 1'b0;
    end else begin
      r_wcnt <= w_next != r_state ? '0 : r_wcnt + 1'b1;
      r_wdog <= w_restart ? 1'b0 : r_wdog | w_to;
    end
  assign bus.wdog_err = r_wdog;
`else
  assign w_to         = 1'b0;
  assign bus.wdog_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state       <= S_LOAD_REQ;
      r_load_start  <= 1'b0;
      r_move_start  <= 1'b0;
      r_write_start <= 1'b0;
      r_done        <= '0;
      r_tick_pend   <= 1'b0;
      r_lives       <= 3'(LIVES);
      r_pellets     <= PELLET_W'(PELLETS_INIT);
      r_result      <= RES_NONE;
    end else begin
      r_state       <= w_next;
      r_load_start  <= w_next == S_LOAD_REQ || w_next == S_RESPAWN;
      r_move_start  <= w_next == S_MOVE_REQ;
      r_write_start <= w_next == S_WRITE_REQ;
      r_done        <= r_move_start ? '0 : r_done | bus.agent_done;
      r_tick_pend   <= r_state == S_TICK_WAIT ? bus.tick && r_tick_pend : r_tick_pend | bus.tick;
      r_lives       <= w_restart ? 3'(LIVES) : (r_state == S_CHECK && r_pellets != '0 && w_hit) ? r_lives - 3'd1 : r_lives;
      r_pellets     <= w_restart ? PELLET_W'(PELLETS_INIT) : w_eat ? r_pellets - 1'b1 : r_pellets;
      r_result      <= w_restart ? RES_NONE : (r_state == S_CHECK && w_next == S_END) ? (r_pellets == '0 ? RES_WIN : RES_LOSE) : r_result;
    end

  assign bus.load_start   = r_load_start;
  assign bus.move_start   = r_move_start;
  assign bus.write_start  = r_write_start;
  assign bus.ready        = r_state == S_READY;
  assign bus.game_over    = r_state == S_END;
  assign bus.user_won     = r_state == S_END && r_result == RES_WIN;
  assign bus.lives_left   = r_lives;
  assign bus.pellets_left = r_pellets;
endmodule

// File: tb/tb_game_round_ctrl.sv
// tb_game_round_ctrl: directed-vector bench for the round sequencer; define GAME_WATCHDOG_EN to exercise the watchdog.
module tb_game_round_ctrl;
  import game_pkg::*;
  localparam int NG = 4, PW = 10;
  logic clk = 1'b0, reset = 1'b0;
  always #5 clk = ~clk;

  game_round_ctrl_if #(.N_GHOSTS(NG), .POS_W(PW), .PELLET_W(8)) bus();
  game_round_ctrl #(.N_GHOSTS(NG), .POS_W(PW), .LIVES(3), .PELLET_W(8), .PELLETS_INIT(240)
`ifdef GAME_WATCHDOG_EN
    , .WDOG_CYC(16)
`endif
  ) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_run = 0, n_fail = 0, n_load = 0, n_move = 0, n_write = 0;
  logic [NG*PW-1:0] g_home, g_t;

  always @(negedge clk) begin
    if (bus.load_start) n_load++;
    if (bus.move_start) n_move++;
    if (bus.write_start) n_write++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic sig(input int w);
    case (w)
      0: return bus.load_start;
      1: return bus.move_start;
      2: return bus.write_start;
      3: return bus.ready;
      default: return bus.game_over;
    endcase
  endfunction

  task automatic wait_for(input string tag, input int w);
    int k = 0;
    while (!sig(w) && k < 50) begin
      step();
      k++;
    end
    if (!sig(w)) chk(tag, 0, 1);
  endtask

  task automatic pulse_load_done();
    bus.load_done = 1'b1; step(); bus.load_done = 1'b0; step();
  endtask

  task automatic pulse_start();
    bus.start = 1'b1; step(); bus.start = 1'b0;
  endtask

  task automatic frame(input int eat_n, input logic [PW-1:0] pac_a, input logic [NG*PW-1:0] g_a, input bit early_tick);
    wait_for("move_start_to", 1);
    step();
    bus.pac_pos = pac_a;
    bus.ghost_pos = g_a;
    for (int i = 0; i < eat_n; i++) begin
      bus.pellet_eaten = 1'b1;
      bus.tick = early_tick && i == 0;
      step();
    end
    bus.pellet_eaten = 1'b0;
    bus.tick = 1'b0;
    bus.agent_done = '1; step(); bus.agent_done = '0;
    wait_for("write_start_to", 2);
    step();
    bus.write_done = 1'b1; step(); bus.write_done = 1'b0;
    step(2);
  endtask

  initial begin
    logic [NG:0] pats [7] = '{5'b00001, 5'b00100, 5'b00000, 5'b00100, 5'b00010, 5'b01000, 5'b10000};
    int m;
    for (int i = 0; i < NG; i++) g_home[i*PW +: PW] = GHOST_START_TILE + PW'(i);
    {bus.tick, bus.start, bus.play_again, bus.load_done, bus.write_done, bus.pellet_eaten} = '0;
    bus.agent_done = '0;
    bus.pac_pos = PAC_START_TILE;
    bus.ghost_pos = g_home;
    // reset state and first load
    step(3);
    chk("rst_load_start", bus.load_start, 0);
    chk("rst_ready", bus.ready, 0);
    chk("rst_game_over", bus.game_over, 0);
    chk("rst_lives", bus.lives_left, 3);
    chk("rst_pellets", bus.pellets_left, 240);
    chk("rst_wdog", bus.wdog_err, 0);
    reset = 1'b1;
    step(5);
    pulse_load_done();
    chk("load_ready", bus.ready, 1);
    chk("load_pulses", n_load, 1);
    chk("load_lives", bus.lives_left, 3);
    chk("load_pellets", bus.pellets_left, 240);
    bus.pellet_eaten = 1'b1; step(); bus.pellet_eaten = 1'b0; step();
    chk("pellet_ignored_ready", bus.pellets_left, 240);
    // staggered agent dones, one repeated
    pulse_start();
    wait_for("move_start_to", 1);
    step();
    foreach (pats[i]) begin
      bus.agent_done = pats[i];
      step();
      chk($sformatf("write_early_%0d", i), bus.write_start, 0);
    end
    bus.agent_done = '0;
    step();
    chk("write_start_hi", bus.write_start, 1);
    step();
    chk("write_start_lo", bus.write_start, 0);
    bus.write_done = 1'b1; step(); bus.write_done = 1'b0; step(2);
    chk("write_pulses", n_write, 1);
    chk("nohit_lives", bus.lives_left, 3);
    m = n_move;
    step(5);
    chk("no_step_without_tick", n_move, m);
    // swap collision
    g_t = g_home; g_t[PW +: PW] = 10'd101;
    bus.pac_pos = 10'd100; bus.ghost_pos = g_t;
    bus.tick = 1'b1; step(); bus.tick = 1'b0;
    g_t[PW +: PW] = 10'd100;
    frame(0, 10'd101, g_t, 1'b0);
    chk("swap_lives", bus.lives_left, 2);
    chk("swap_load_pulse", n_load, 2);
    chk("swap_not_over", bus.game_over, 0);
    pulse_load_done();
    chk("swap_ready", bus.ready, 1);
    // two more direct collisions -> lose
    bus.pac_pos = PAC_START_TILE; bus.ghost_pos = g_home;
    pulse_start();
    frame(0, GHOST_START_TILE, g_home, 1'b0);
    chk("hit2_lives", bus.lives_left, 1);
    pulse_load_done();
    bus.pac_pos = PAC_START_TILE;
    pulse_start();
    frame(0, GHOST_START_TILE, g_home, 1'b0);
    chk("lose_lives", bus.lives_left, 0);
    chk("lose_over", bus.game_over, 1);
    chk("lose_won", bus.user_won, 0);
    chk("lose_load_pulses", n_load, 3);
    bus.play_again = 1'b1; step(); bus.play_again = 1'b0; step(2);
    chk("again_lives", bus.lives_left, 3);
    chk("again_over", bus.game_over, 0);
    chk("again_load_pulse", n_load, 4);
    pulse_load_done();
    chk("again_ready", bus.ready, 1);
    // drain all pellets; pending tick chains frames; win beats collision
    bus.pac_pos = PAC_START_TILE;
    m = n_move;
    pulse_start();
    for (int f = 0; f < 19; f++) begin
      frame(12, PAC_START_TILE, g_home, 1'b1);
      if (f == 0) chk("pellets_after_1", bus.pellets_left, 228);
    end
    frame(13, GHOST_START_TILE, g_home, 1'b0);
    chk("win_pellets_sat", bus.pellets_left, 0);
    chk("win_over", bus.game_over, 1);
    chk("win_won", bus.user_won, 1);
    chk("win_lives", bus.lives_left, 3);
    chk("win_moves", n_move - m, 20);
`ifdef GAME_WATCHDOG_EN
    bus.play_again = 1'b1; step(); bus.play_again = 1'b0; step(2);
    chk("wd_won_clr", bus.user_won, 0);
    pulse_load_done();
    bus.pac_pos = PAC_START_TILE;
    pulse_start();
    wait_for("move_start_to", 1);
    step();
    bus.agent_done = '1; step(); bus.agent_done = '0;
    wait_for("write_start_to", 2);
    step(16);
    chk("wd_c16_err", bus.wdog_err, 0);
    chk("wd_c16_over", bus.game_over, 0);
    step();
    chk("wd_c17_err", bus.wdog_err, 1);
    chk("wd_c17_over", bus.game_over, 1);
    chk("wd_c17_won", bus.user_won, 0);
    bus.play_again = 1'b1; step(); bus.play_again = 1'b0; step(2);
    chk("wd_clr_on_load", bus.wdog_err, 0);
`else
    chk("wdog_off", bus.wdog_err, 0);
`endif
    // asynchronous reset mid-round
    reset = 1'b0;
    step();
    chk("midrst_over", bus.game_over, 0);
    chk("midrst_lives", bus.lives_left, 3);
    chk("midrst_pellets", bus.pellets_left, 240);
    reset = 1'b1;
    step(2);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
